// File: rtl/cam_pkg.sv
// Shared types and helpers for the OV7670 capture path.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 12;

    // Even byte carries R in its low nibble; odd byte is {G,B}.
    function automatic logic [PIX_W-1:0] rgb444_pack(input logic [3:0] red,
                                                     input logic [7:0] green_blue);
        return {red, green_blue};
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Rise/fall pulse generator for an already-registered level.
module cam_edge_det (
    input  logic pclk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream capture: RGB444 pixel packing into linear frame-buffer writes.
// state   | meaning
// WAIT_VS | idle until the next frame start (vsync fall)
// SKIP    | settling frame after reset, no writes
// CAPTURE | frame being written to the frame buffer
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic              line_err,
    output logic              ovf_err
);
    localparam int                AW1       = ADDR_W + 1;
    localparam int                COL_W     = $clog2(H_ACTIVE + 2);
    localparam logic [COL_W-1:0]  COL_FULL  = COL_W'(H_ACTIVE);
    localparam logic [COL_W-1:0]  COL_MAX   = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [ADDR_W:0]   ROW_STEP  = AW1'(H_ACTIVE);
    localparam logic [ADDR_W:0]   TOTAL     = AW1'(H_ACTIVE * V_ACTIVE);

    logic              r_vs;
    logic              r_href;
    logic [7:0]        r_data;
    logic              vs_rise;
    logic              vs_fall;
    logic              href_rise;
    logic              href_fall;

    cap_state_t        state;
    cap_state_t        state_next;
    logic [7:0]        skip_cnt;
    logic              phase;
    logic [3:0]        red;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] pix_addr;
    logic              full;

    logic              cap_start;
    logic              cap_end;
    logic              skip_dec;
    logic              accept;
    logic              line_close;
    logic              line_bad;
    logic [ADDR_W:0]   next_row;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_vs   <= 1'b0;
            r_href <= 1'b0;
            r_data <= 8'd0;
        end else begin
            r_vs   <= cam_vsync;
            r_href <= cam_href;
            r_data <= cam_data;
        end
    end

    cam_edge_det u_vs_edge (
        .pclk  (pclk),
        .rst   (rst),
        .level (r_vs),
        .rise  (vs_rise),
        .fall  (vs_fall)
    );

    cam_edge_det u_href_edge (
        .pclk  (pclk),
        .rst   (rst),
        .level (r_href),
        .rise  (href_rise),
        .fall  (href_fall)
    );

    always_comb begin
        state_next = state;
        cap_start  = 1'b0;
        cap_end    = 1'b0;
        skip_dec   = 1'b0;
        accept     = 1'b0;
        line_close = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_fall) begin
                    state_next = (skip_cnt != 8'd0) ? SKIP : CAPTURE;
                    cap_start  = 1'b1;
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    state_next = WAIT_VS;
                    skip_dec   = 1'b1;
                end
            end
            CAPTURE: begin
                // A line still open at frame end is closed in the same cycle.
                line_close = href_fall | (vs_rise & r_href);
                accept     = r_href & ~vs_rise;
                if (vs_rise) begin
                    state_next = WAIT_VS;
                    cap_end    = 1'b1;
                end else if (vs_fall) begin
                    cap_start  = 1'b1;
                end
            end
            default: state_next = WAIT_VS;
        endcase
    end

    assign line_bad = phase | (col != COL_FULL);
    assign next_row = {1'b0, row_base} + ROW_STEP;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_VS;
            skip_cnt   <= 8'(SKIP_FRAMES);
            phase      <= 1'b0;
            red        <= 4'd0;
            col        <= '0;
            row_base   <= '0;
            pix_addr   <= '0;
            full       <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            line_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state      <= state_next;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            if (skip_dec) skip_cnt <= skip_cnt - 8'd1;

            if (cap_end) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 8'd1;
            end

            if (cap_start) begin
                pix_addr <= '0;
                row_base <= '0;
                phase    <= 1'b0;
                col      <= '0;
                full     <= 1'b0;
            end else begin
                if (href_rise) begin
                    phase <= 1'b0;
                    col   <= '0;
                end
                if (accept) begin
                    if (!phase) begin
                        red   <= r_data[3:0];
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if (col != COL_MAX) col <= col + 1'b1;
                        if (full) begin
                            ovf_err <= 1'b1;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_addr <= pix_addr;
                            wr_data <= rgb444_pack(red, r_data);
                            if (pix_addr == LAST_ADDR) full <= 1'b1;
                            else                       pix_addr <= pix_addr + 1'b1;
                        end
                    end
                end
                if (line_close) begin
                    phase <= 1'b0;
                    col   <= '0;
                    if (line_bad) line_err <= 1'b1;
                    // Once the frame is full, address and row base stay put.
                    if (!full) begin
                        row_base <= next_row[ADDR_W-1:0];
                        if (line_bad) begin
                            if (next_row >= TOTAL) full     <= 1'b1;
                            else                   pix_addr <= next_row[ADDR_W-1:0];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomized scoreboard bench for ov7670_capture (two sizes: 16x8 skip 2, 8x4 skip 0).
module tb_ov7670_capture;
    localparam int HA = 16, VA = 8, SA = 2;
    localparam int HB = 8,  VB = 4, SB = 0;
    localparam int AW = 19;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    logic vs   = 1'b1;
    logic href = 1'b0;
    logic [7:0] data = 8'd0;
    int sel = 0;

    logic          vs_a, href_a, vs_b, href_b;
    logic [7:0]    data_a, data_b;
    logic          wr_en_a, wr_en_b, fdone_a, fdone_b, lerr_a, lerr_b, ovf_a, ovf_b;
    logic [AW-1:0] wr_addr_a, wr_addr_b;
    logic [11:0]   wr_data_a, wr_data_b;
    logic [7:0]    fcnt_a, fcnt_b;

    assign vs_a   = (sel == 0) ? vs   : 1'b1;
    assign href_a = (sel == 0) ? href : 1'b0;
    assign data_a = (sel == 0) ? data : 8'd0;
    assign vs_b   = (sel == 1) ? vs   : 1'b1;
    assign href_b = (sel == 1) ? href : 1'b0;
    assign data_b = (sel == 1) ? data : 8'd0;

    ov7670_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW), .SKIP_FRAMES(SA)) dut_a (
        .pclk(pclk), .rst(rst), .cam_vsync(vs_a), .cam_href(href_a), .cam_data(data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .frame_done(fdone_a),
        .frame_cnt(fcnt_a), .line_err(lerr_a), .ovf_err(ovf_a));

    ov7670_capture #(.H_ACTIVE(HB), .V_ACTIVE(VB), .ADDR_W(AW), .SKIP_FRAMES(SB)) dut_b (
        .pclk(pclk), .rst(rst), .cam_vsync(vs_b), .cam_href(href_b), .cam_data(data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .frame_done(fdone_b),
        .frame_cnt(fcnt_b), .line_err(lerr_b), .ovf_err(ovf_b));

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [30:0] exp_a[$];
    logic [30:0] exp_b[$];
    logic [30:0] ea, eb;
    int wr_a = 0, wr_b = 0, fd_a = 0, fd_b = 0;
    int addr0_cyc = 0, drive_cyc = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int hp[2] = '{HA, HB};
    int vp[2] = '{VA, VB};
    int m_skip[2] = '{SA, SB};
    int m_fcnt[2] = '{0, 0};
    int m_lerr[2] = '{0, 0};
    int m_ovf[2]  = '{0, 0};
    int m_wr[2]   = '{0, 0};
    int m_fd[2]   = '{0, 0};
    int lens[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge pclk) begin
        #1;
        if (wr_en_a) begin
            wr_a++;
            if (wr_addr_a == '0) addr0_cyc = cyc;
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL write_a actual=addr %0d data %03h required=no write", wr_addr_a, wr_data_a);
            end else begin
                ea = exp_a.pop_front();
                check("write_a", {wr_addr_a, wr_data_a}, ea);
            end
        end
        if (wr_en_b) begin
            wr_b++;
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL write_b actual=addr %0d data %03h required=no write", wr_addr_b, wr_data_b);
            end else begin
                eb = exp_b.pop_front();
                check("write_b", {wr_addr_b, wr_data_b}, eb);
            end
        end
        if (fdone_a) fd_a++;
        if (fdone_b) fd_b++;
    end

    task automatic push(input int d, input logic [30:0] e);
        if (d == 0) exp_a.push_back(e);
        else        exp_b.push_back(e);
    endtask

    task automatic set_lens(input int n, input int len);
        lens.delete();
        for (int i = 0; i < n; i++) lens.push_back(len);
    endtask

    // Drives one frame and records the writes the camera-side rules call for.
    task automatic send_frame(input bit hold_href, input bit fixed_first);
        int d = sel;
        int h = hp[d];
        int total = hp[d] * vp[d];
        bit capt = (m_skip[d] == 0);
        int addr = 0;
        bit full = 0;
        int n;
        logic [3:0] r = 4'd0;
        logic [7:0] bv;
        @(negedge pclk); vs = 1'b0;
        repeat (2) @(negedge pclk);
        for (int li = 0; li < lens.size(); li++) begin
            n = lens[li];
            for (int b = 0; b < n; b++) begin
                @(negedge pclk);
                bv = 8'($urandom);
                if (fixed_first && li == 0 && b == 0) bv = 8'h0A;
                if (fixed_first && li == 0 && b == 1) bv = 8'h5C;
                href = 1'b1; data = bv;
                if (b % 2 == 0) r = bv[3:0];
                else begin
                    if (fixed_first && li == 0 && b == 1) drive_cyc = cyc;
                    if (capt) begin
                        if (full) m_ovf[d] = 1;
                        else begin
                            push(d, {AW'(addr), r, bv});
                            m_wr[d]++;
                            if (addr == total - 1) full = 1;
                            else addr++;
                        end
                    end
                end
            end
            if (hold_href && li == lens.size() - 1) begin
                @(negedge pclk); vs = 1'b1;
                @(negedge pclk); href = 1'b0;
            end else begin
                @(negedge pclk); href = 1'b0;
                repeat (2) @(negedge pclk);
            end
            if (capt && (n % 2 != 0 || n / 2 != h)) begin
                m_lerr[d] = 1;
                if (!full) begin
                    if ((li + 1) * h >= total) full = 1;
                    else addr = (li + 1) * h;
                end
            end
        end
        if (!hold_href) begin @(negedge pclk); vs = 1'b1; end
        repeat (4) @(negedge pclk);
        if (capt) begin
            m_fcnt[d] = (m_fcnt[d] + 1) % 256;
            m_fd[d]++;
        end else m_skip[d]--;
    endtask

    task automatic check_frame(input string tag);
        if (sel == 0) begin
            check({tag, "_pending_a"}, exp_a.size(), 0);
            check({tag, "_writes_a"}, wr_a, m_wr[0]);
            check({tag, "_frame_cnt_a"}, fcnt_a, m_fcnt[0]);
            check({tag, "_frame_done_a"}, fd_a, m_fd[0]);
            check({tag, "_line_err_a"}, lerr_a, m_lerr[0]);
            check({tag, "_ovf_err_a"}, ovf_a, m_ovf[0]);
        end else begin
            check({tag, "_pending_b"}, exp_b.size(), 0);
            check({tag, "_writes_b"}, wr_b, m_wr[1]);
            check({tag, "_frame_cnt_b"}, fcnt_b, m_fcnt[1]);
            check({tag, "_frame_done_b"}, fd_b, m_fd[1]);
            check({tag, "_line_err_b"}, lerr_b, m_lerr[1]);
            check({tag, "_ovf_err_b"}, ovf_b, m_ovf[1]);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, wr_en_a, 0);
        check({tag, "_wr_addr"}, wr_addr_a, 0);
        check({tag, "_wr_data"}, wr_data_a, 0);
        check({tag, "_frame_done"}, fdone_a, 0);
        check({tag, "_frame_cnt"}, fcnt_a, 0);
        check({tag, "_line_err"}, lerr_a, 0);
        check({tag, "_ovf_err"}, ovf_a, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [7:0] bv;
        r = 4'd0;
        repeat (3) @(negedge pclk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge pclk);

        // Two settling frames, then a captured frame starting with 0x0A,0x5C
        set_lens(VA, 2 * HA);
        send_frame(1'b0, 1'b0); check_frame("skip1");
        send_frame(1'b0, 1'b0); check_frame("skip2");
        send_frame(1'b0, 1'b1); check_frame("frame3");
        check("first_px_latency", addr0_cyc - drive_cyc, 2);

        // Odd byte count on line 3
        set_lens(VA, 2 * HA);
        lens[3] = 2 * HA - 1;
        send_frame(1'b0, 1'b0); check_frame("odd_line");
        check("line_err_sticky", lerr_a, 1);

        // One line too many
        set_lens(VA + 1, 2 * HA);
        send_frame(1'b0, 1'b0); check_frame("ovf");
        check("ovf_addr_hold", wr_addr_a, HA * VA - 1);

        // Reset in the middle of a captured line
        @(negedge pclk); vs = 1'b0;
        repeat (2) @(negedge pclk);
        for (int b = 0; b < 11; b++) begin
            @(negedge pclk);
            bv = 8'($urandom);
            href = 1'b1; data = bv;
            if (b % 2 == 0) r = bv[3:0];
            else begin
                push(0, {AW'(b / 2), r, bv});
                m_wr[0]++;
            end
        end
        @(negedge pclk);
        check("mid_rst_pending", exp_a.size(), 0);
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        exp_a.delete();
        m_skip[0] = SA; m_fcnt[0] = 0; m_lerr[0] = 0; m_ovf[0] = 0;
        @(negedge pclk); rst = 1'b0;
        @(negedge pclk); href = 1'b0;
        @(negedge pclk); vs = 1'b1;
        repeat (3) @(negedge pclk);
        set_lens(VA, 2 * HA);
        send_frame(1'b0, 1'b0); check_frame("rst_skip1");
        send_frame(1'b0, 1'b0); check_frame("rst_skip2");
        // Short last line still open when vsync rises
        lens[VA - 1] = 2 * HA - 2;
        send_frame(1'b1, 1'b0); check_frame("rst_capture");

        // 256 small frames without settling skip
        sel = 1;
        repeat (3) @(negedge pclk);
        set_lens(VB, 2 * HB);
        for (int f = 0; f < 256; f++) begin
            send_frame(bit'($urandom_range(0, 1)), 1'b0);
            check_frame("wrap");
            if (f == 254) check("frame_cnt_255", fcnt_b, 255);
        end
        check("frame_cnt_wrap", fcnt_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
